// File: rtl/snail_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first on D and
// keeps a golden count of the pulses a snail detector on D will produce.
module snail_tx #(
  parameter int WIDTH  = 8,
  parameter int GAP    = 1,
  parameter int HITS_W = $clog2(WIDTH/2+1)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_data,
  output logic              D,
  output logic              busy,
  output logic              last,
  output logic              done,
  output logic [HITS_W-1:0] hits
);

  // state    | meaning
  // ST_IDLE  | waiting for a word, load_ready high
  // ST_SHIFT | data bits on D, cnt = index of bit currently on D
  // ST_GAP   | D held low, cnt = gap cycles remaining minus one
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sreg;
  logic               rdy;
  logic               cnt_tc;

  assign cnt_tc = (cnt == '0);

  always_ff @(posedge clk) begin
    if (res) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        last = cnt_tc;
        if (cnt_tc) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        busy = 1'b1;
        if (cnt_tc) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      D    <= 1'b0;
      done <= 1'b0;
      hits <= '0;
      rdy  <= 1'b0;
      cnt  <= '0;
      sreg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            D    <= load_data[WIDTH-1];
            sreg <= {load_data[WIDTH-2:0], 1'b0};
            cnt  <= CNT_W'(WIDTH-1);
            hits <= '0;
            rdy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // Mirror of the detector, fed with the bit leaving D this cycle
          if (D) begin
            if (rdy) begin
              hits <= hits + HITS_W'(1);
              rdy  <= 1'b0;
            end else begin
              rdy  <= 1'b1;
            end
          end else begin
            rdy <= 1'b0;
          end
          if (cnt_tc) begin
            D   <= 1'b0;
            cnt <= CNT_W'(GAP-1);
          end else begin
            D    <= sreg[WIDTH-1];
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_tc) done <= 1'b1;
          else        cnt  <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
